ddr_rx_deserializer: RTL and testbench
======================================

Name: ddr_rx_deserializer

Overview:
- Receive end of the dual-edge (DDR) serial link. The far end drives one bit while clk is high and one bit while clk is low.
- This block samples the line on both clock edges and pairs the samples into 2-bit beats.
- Beats are assembled LSB-first into WORD_W-bit words, which are buffered in a small FIFO and presented on a valid/ready interface to the SoC fabric.
- Framing violations and buffer overflow are reported through sticky error flags.

Parameters:
- WORD_W, 8, deserialized word width; must be even and >= 2.
- FIFO_DEPTH, 4, number of output word entries; power of two, >= 2.

Ports:
- clk  input  1  link/system clock; both edges are used for sampling.
- arst_ni  input  1  asynchronous active-low reset.
- ddr_en_i  input  1  frame qualifier; DDR-driven like the data line.
- ddr_d_i  input  1  DDR serial data.
- word_o  output  WORD_W  head-of-FIFO word.
- valid_o  output  1  FIFO non-empty.
- ready_i  input  1  consumer accepts word_o when valid_o && ready_i at posedge.
- frame_err_o  output  1  sticky framing error.
- overflow_o  output  1  sticky overflow (word dropped).
- clr_err_i  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset:
  - arst_ni low asynchronously clears the negedge sample regs, the beat counter, the shift reg, the FIFO pointers and count, and both error flags.
  - Outputs during reset: valid_o=0, word_o=0, frame_err_o=0, overflow_o=0.
  - Reset mid-word discards the partial word and all FIFO contents.
- Sampling:
  - Negedge regs (en_f, d_f) capture ddr_en_i/ddr_d_i at each negedge. This is the high-phase bit, i.e. the first bit in time.
  - At the following posedge, ddr_en_i/ddr_d_i are captured as the low-phase bit (second in time). The beat is {d_rise, d_fall}.
- Beat valid:
  - A beat is valid iff en_f=1 and ddr_en_i=1 at that posedge.
  - Bit order: word[2i] = fall sample of beat i; word[2i+1] = rise sample of beat i.
- Beat counter:
  - Width clog2(WORD_W/2), range 0..WORD_W/2-1.
  - Increments on each valid beat.
  - On a valid beat with counter = WORD_W/2-1, the completed word is pushed into the FIFO at that same posedge and the counter wraps to 0.
- Latency: valid_o rises immediately after the posedge that samples the last bit of a word. word_o is registered from FIFO storage, with no combinational path from ddr_d_i.
- Framing errors:
  - en_f != ddr_en_i at a posedge (half-qualified beat): discard the partial word, set counter to 0, set frame_err_o.
  - en_f=ddr_en_i=0 with counter != 0 (frame ended mid-word): discard the partial word, set counter to 0, set frame_err_o.
  - Idle (both en 0, counter 0): no action.
- FIFO:
  - Push and pop in the same cycle are both performed, including when full; no overflow in that case.
  - Push when full with no pop: the word is dropped, overflow_o is set, and FIFO contents are unchanged.
  - Pop when empty: ignored.
  - word_o is stable while valid_o && !ready_i.
- Sticky flags:
  - clr_err_i clears both flags at the posedge.
  - If a new error occurs in the same cycle as clr_err_i, the set wins.

Decomposition:
- Shared package ddr_link_pkg holds:
  - the beat typedef (2-bit, fields rise/fall);
  - the bit-order constant (LSB-first) shared with the DDR transmitter;
  - a function computing the beat-counter width from WORD_W.
- Natural sub-module: ddr_rx_fifo, a synchronous FIFO parameterized by width/depth with push, pop, full, empty and registered read data.
- The negedge capture stays in the top as its own always_ff on negedge clk with async reset.

Test Plan:
- Byte 0xA5, LSB first (ddr_d_i sequence 1,0,1,0,0,1,0,1 over 4 periods, ddr_en_i=1 throughout, ready_i=0) -> valid_o=1 after the 4th posedge, word_o=0xA5, frame_err_o=0.
- Back-to-back 0x3C, 0xFF, 0x00 with ready_i=1 -> three single-cycle handshakes in order, one word per 4 clocks, overflow_o=0.
- ready_i=0, send 5 words 0x01..0x05 -> FIFO holds 0x01..0x04, 0x05 dropped, overflow_o=1; then drain with ready_i=1 -> reads 0x01..0x04, valid_o=0 after.
- Full FIFO, final word arrives on the same posedge as a pop -> 0x05 retained, overflow_o=0.
- Framing faults:
  - ddr_en_i drops after 2 beats -> no word pushed, frame_err_o=1.
  - ddr_en_i high in only one half of a period -> frame_err_o=1.
  - In both cases, clr_err_i pulse -> flag clears, then a following 0x5A is received correctly.
- arst_ni asserted after 3 beats of a word with 2 words queued -> all outputs 0 immediately; after release, new word 0xC3 is received with no stale data.

Source files
------------

// File: rtl/ddr_link_pkg.sv
// Definitions shared by both ends of the DDR serial link: beat layout,
// bit ordering and beat-counter sizing.
package ddr_link_pkg;

    typedef struct packed {
        logic rise;
        logic fall;
    } beat_t;

    // The first beat of a word lands in the least significant bit pair.
    localparam bit LSB_FIRST = 1'b1;

    function automatic int beat_cnt_w(input int word_w);
        int n;
        n = $clog2(word_w / 2);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/ddr_rx_fifo.sv
// Small synchronous FIFO with registered head-of-queue read data and
// registered full/empty flags.
module ddr_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next_s;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push_s, do_pop_s;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    always_comb begin
        do_pop_s  = pop_i & (count_q != '0);
        do_push_s = push_i & ((count_q != FULL_CNT) | do_pop_s);
        rd_next_s = rd_ptr_q + PTR_W'(1);
        wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? rd_next_s : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    // Next head word: the entry behind the popped one, or the incoming word when it becomes the head.
    always_comb begin
        rdata_d = rdata_q;
        if (do_pop_s) begin
            if (count_q > CNT_W'(1)) begin
                rdata_d = mem_q[rd_next_s];
            end else if (do_push_s) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = rdata_q;
            end
        end else if (do_push_s && (count_q == '0)) begin
            rdata_d = wdata_i;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage array; contents are meaningless until pointers say otherwise, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer, occupancy and head-word registers.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata_o = rdata_q;
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/ddr_rx_deserializer.sv
// DDR link receiver: samples the line on both clock edges, assembles beats
// into words, queues them and reports framing and overflow errors.
module ddr_rx_deserializer
    import ddr_link_pkg::*;
#(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              arst_ni,
    input  logic              ddr_en_i,
    input  logic              ddr_d_i,
    output logic [WORD_W-1:0] word_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              frame_err_o,
    output logic              overflow_o,
    input  logic              clr_err_i
);

    localparam int CNT_W = beat_cnt_w(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W / 2 - 1);

    logic              en_f_q, d_f_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d, slot_s;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic              frame_err_q, frame_err_d, overflow_q, overflow_d;
    logic              beat_valid_s, framing_s, push_s, full_s, empty_s;
    beat_t             beat_s;

    // High-phase half of each beat, captured at the falling edge.
    always_ff @(negedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            en_f_q <= 1'b0;
            d_f_q  <= 1'b0;
        end else begin
            en_f_q <= ddr_en_i;
            d_f_q  <= ddr_d_i;
        end
    end

    // Beat qualification and word assembly; a bad beat or early frame end discards the partial word.
    always_comb begin
        beat_s.rise  = ddr_d_i;
        beat_s.fall  = d_f_q;
        beat_valid_s = en_f_q & ddr_en_i;
        framing_s    = (en_f_q ^ ddr_en_i) | (~en_f_q & ~ddr_en_i & (cnt_q != '0));
        slot_s       = LSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);
        cnt_d        = cnt_q;
        sr_d         = sr_q;
        push_s       = 1'b0;
        if (beat_valid_s) begin
            sr_d[{slot_s, 1'b0} +: 2] = beat_s;
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                push_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (framing_s) begin
            cnt_d = '0;
            sr_d  = '0;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Sticky flags: a fresh error outranks a simultaneous clear. A pop always accompanies ready_i when full.
    always_comb begin
        frame_err_d = (frame_err_q & ~clr_err_i) | framing_s;
        overflow_d  = (overflow_q & ~clr_err_i) | (push_s & full_s & ~ready_i);
    end

    // Assembly state and error flags.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt_q       <= '0;
            sr_q        <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    ddr_rx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .arst_ni (arst_ni),
        .push_i  (push_s),
        .wdata_i (sr_d),
        .pop_i   (ready_i),
        .rdata_o (word_o),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign valid_o     = ~empty_s;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_ddr_rx_deserializer.sv
// Directed bench for ddr_rx_deserializer: words are driven bit by bit on both
// clock phases and outputs are checked one time unit after each rising edge.
module tb_ddr_rx_deserializer;

    logic       clk;
    logic       arst_ni;
    logic       ddr_en_i;
    logic       ddr_d_i;
    logic [7:0] word_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overflow_o;
    logic       clr_err_i;

    int n_checks = 0;
    int n_fail   = 0;

    ddr_rx_deserializer #(.WORD_W(8), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .arst_ni     (arst_ni),
        .ddr_en_i    (ddr_en_i),
        .ddr_d_i     (ddr_d_i),
        .word_o      (word_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .clr_err_i   (clr_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts at posedge+1: high-phase bit, then low-phase bit; ends at posedge+1 after sampling.
    task automatic drive_beat(input logic eh, input logic dh, input logic el, input logic dl);
        ddr_en_i = eh;
        ddr_d_i  = dh;
        @(negedge clk);
        #1;
        ddr_en_i = el;
        ddr_d_i  = dl;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 4; i++) drive_beat(1'b1, w[2*i], 1'b1, w[2*i+1]);
    endtask

    task automatic go_idle(input int n);
        for (int i = 0; i < n; i++) drive_beat(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        arst_ni = 1'b0; ddr_en_i = 1'b0; ddr_d_i = 1'b0; ready_i = 1'b0; clr_err_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_checks++; if (word_o !== 8'h00) begin n_fail++; $display("FAIL reset_word: got %h want 00", word_o); end
        n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow_o); end
        arst_ni = 1'b1;
        go_idle(1);
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b want 0", valid_o); end
    endtask

    task automatic test_single_word();
        send_word(8'hA5);
        n_checks++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL a5_valid: got %b want 1", valid_o); end
        n_checks++; if (word_o !== 8'hA5) begin n_fail++; $display("FAIL a5_word: got %h want a5", word_o); end
        n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL a5_ferr: got %b want 0", frame_err_o); end
        go_idle(2);
        n_checks++; if (word_o !== 8'hA5 || valid_o !== 1'b1) begin n_fail++; $display("FAIL a5_hold: got %h/%b want a5/1", word_o, valid_o); end
        ready_i = 1'b1;
        go_idle(1);
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL a5_pop: got %b want 0", valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w [3];
        w[0] = 8'h3C; w[1] = 8'hFF; w[2] = 8'h00;
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) begin
                drive_beat(1'b1, w[k][2*i], 1'b1, w[k][2*i+1]);
                if (i == 0 && k > 0) begin
                    n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_single_cycle%0d: got %b want 0", k, valid_o); end
                end
            end
            n_checks++; if (valid_o !== 1'b1 || word_o !== w[k]) begin n_fail++; $display("FAIL b2b_word%0d: got %h/%b want %h/1", k, word_o, valid_o, w[k]); end
        end
        go_idle(1);
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %b want 0", valid_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", overflow_o); end
    endtask

    task automatic test_overflow();
        for (int v = 1; v <= 5; v++) send_word(8'(v));
        go_idle(1);
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow_o); end
        ready_i = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            n_checks++; if (valid_o !== 1'b1 || word_o !== 8'(v)) begin n_fail++; $display("FAIL ovf_drain%0d: got %h/%b want %h/1", v, word_o, valid_o, 8'(v)); end
            go_idle(1);
        end
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", valid_o); end
        clr_err_i = 1'b1;
        go_idle(1);
        clr_err_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", overflow_o); end
    endtask

    task automatic test_pop_on_full();
        logic [7:0] w5;
        w5 = 8'h05;
        for (int v = 1; v <= 4; v++) send_word(8'(v));
        for (int i = 0; i < 3; i++) drive_beat(1'b1, w5[2*i], 1'b1, w5[2*i+1]);
        ready_i = 1'b1;
        drive_beat(1'b1, w5[6], 1'b1, w5[7]);
        ready_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL pf_ovf: got %b want 0", overflow_o); end
        n_checks++; if (valid_o !== 1'b1 || word_o !== 8'h02) begin n_fail++; $display("FAIL pf_head: got %h/%b want 02/1", word_o, valid_o); end
        go_idle(1);
        ready_i = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            n_checks++; if (valid_o !== 1'b1 || word_o !== 8'(v)) begin n_fail++; $display("FAIL pf_drain%0d: got %h/%b want %h/1", v, word_o, valid_o, 8'(v)); end
            go_idle(1);
        end
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL pf_empty: got %b want 0", valid_o); end
    endtask

    task automatic recv_5a(input string tag);
        send_word(8'h5A);
        n_checks++; if (valid_o !== 1'b1 || word_o !== 8'h5A) begin n_fail++; $display("FAIL %s_5a: got %h/%b want 5a/1", tag, word_o, valid_o); end
        n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL %s_5a_ferr: got %b want 0", tag, frame_err_o); end
        ready_i = 1'b1;
        go_idle(1);
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL %s_5a_pop: got %b want 0", tag, valid_o); end
    endtask

    task automatic test_frame_drop();
        drive_beat(1'b1, 1'b0, 1'b1, 1'b1);
        drive_beat(1'b1, 1'b0, 1'b1, 1'b1);
        go_idle(1);
        n_checks++; if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL drop_ferr: got %b want 1", frame_err_o); end
        go_idle(1);
        n_checks++; if (frame_err_o !== 1'b1 || valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_sticky: got %b/%b want 1/0", frame_err_o, valid_o); end
        clr_err_i = 1'b1;
        go_idle(1);
        clr_err_i = 1'b0;
        n_checks++; if (frame_err_o !== 1'b0) begin n_fail++; $display("FAIL drop_clear: got %b want 0", frame_err_o); end
        recv_5a("drop");
    endtask

    task automatic test_frame_half();
        drive_beat(1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL half_hi_ferr: got %b want 1", frame_err_o); end
        clr_err_i = 1'b1;
        drive_beat(1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++; if (frame_err_o !== 1'b1) begin n_fail++; $display("FAIL half_set_wins: got %b want 1", frame_err_o); end
        go_idle(1);
        clr_err_i = 1'b0;
        n_checks++; if (frame_err_o !== 1'b0 || valid_o !== 1'b0) begin n_fail++; $display("FAIL half_clear: got %b/%b want 0/0", frame_err_o, valid_o); end
        recv_5a("half");
    endtask

    task automatic test_reset_midword();
        logic [7:0] wc;
        wc = 8'hC3;
        send_word(8'h11);
        send_word(8'h22);
        for (int i = 0; i < 3; i++) drive_beat(1'b1, wc[2*i], 1'b1, wc[2*i+1]);
        arst_ni = 1'b0;
        ddr_en_i = 1'b0;
        ddr_d_i  = 1'b0;
        #1;
        n_checks++; if (valid_o !== 1'b0 || word_o !== 8'h00) begin n_fail++; $display("FAIL mid_rst_out: got %h/%b want 00/0", word_o, valid_o); end
        n_checks++; if (frame_err_o !== 1'b0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: got %b/%b want 0/0", frame_err_o, overflow_o); end
        @(posedge clk);
        #1;
        arst_ni = 1'b1;
        go_idle(1);
        n_checks++; if (valid_o !== 1'b0 || frame_err_o !== 1'b0) begin n_fail++; $display("FAIL mid_post_rst: got %b/%b want 0/0", valid_o, frame_err_o); end
        send_word(wc);
        n_checks++; if (valid_o !== 1'b1 || word_o !== 8'hC3) begin n_fail++; $display("FAIL mid_c3: got %h/%b want c3/1", word_o, valid_o); end
        ready_i = 1'b1;
        go_idle(1);
        ready_i = 1'b0;
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_no_stale: got %b want 0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overflow();
        test_pop_on_full();
        test_frame_drop();
        test_frame_half();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
